// File: rtl/fas_frame_sched.sv
// fas_frame_sched
//   Frame scheduler between the FIR stage and the shared FFT engine. The
//   FIR sample stream is packed into FRAME_LEN-sample frames inside a
//   two-bank ping-pong buffer. Each time a bank fills, the FFT is launched
//   on it. Once NUM_FRAMES frames have been transformed, the frequency-
//   analysis stage is launched. If both banks are full when a sample
//   arrives, that sample is dropped and a sticky overflow flag is set.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   fir_valid  fir_d is valid this cycle
//   fir_d      FIR output sample (DW bits, 8.8 fixed point)
//   wr_en      buffer write strobe (registered)
//   wr_addr    {bank, index} buffer write address (registered)
//   wr_data    registered copy of fir_d
//   fft_start  one-cycle FFT launch pulse
//   fft_bank   bank the FFT reads; stable from fft_start until fft_done
//   fft_done   one-cycle pulse: the FFT has finished with fft_bank
//   ana_start  one-cycle analysis launch pulse
//   ana_done   one-cycle pulse: the analysis result is valid
//   frame_cnt  frames completed by the FFT, 0..NUM_FRAMES
//   overflow   sticky; at least one sample was dropped
//   done       run complete; held until reset
module fas_frame_sched #(
    parameter int DW         = 16,
    parameter int FRAME_LEN  = 16,
    parameter int NUM_FRAMES = 64,
    localparam int IW = $clog2(FRAME_LEN),
    // frame_cnt must be able to hold NUM_FRAMES itself, hence the +1
    localparam int CW = $clog2(NUM_FRAMES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fir_valid,
    input  logic [DW-1:0] fir_d,
    output logic          wr_en,
    output logic [IW:0]   wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          fft_start,
    output logic          fft_bank,
    input  logic          fft_done,
    output logic          ana_start,
    input  logic          ana_done,
    output logic [CW-1:0] frame_cnt,
    output logic          overflow,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_FFT, S_ANA, S_WAIT_ANA, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            wr_bank_q, wr_bank_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic            rd_bank_q, rd_bank_d;
    logic [1:0]      full_q, full_d;
    logic [CW-1:0]   frames_wr_q, frames_wr_d;
    logic            wr_en_q, wr_en_d;
    logic [IW:0]     wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            fft_start_q, fft_start_d;
    logic            fft_bank_q, fft_bank_d;
    logic            ana_start_q, ana_start_d;
    logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
    logic            overflow_q, overflow_d;
    logic            done_q, done_d;

    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        frames_wr_d = frames_wr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        fft_start_d = 1'b0;
        fft_bank_d  = fft_bank_q;
        ana_start_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q;
        done_d      = done_q;

        // Read side first: a bank released by fft_done this cycle is only
        // cleared in full_d, so the write side below still sees it as full
        // via full_q and drops any sample aimed at it this same cycle.
        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d     = S_START;
                    fft_start_d = 1'b1;
                    fft_bank_d  = rd_bank_q;
                end
            end
            S_START: state_d = S_WAIT_FFT;
            S_WAIT_FFT: begin
                if (fft_done) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    if (frame_cnt_q != CW'(NUM_FRAMES))
                        frame_cnt_d = frame_cnt_q + CW'(1);
                    if (frame_cnt_d == CW'(NUM_FRAMES)) begin
                        state_d     = S_ANA;
                        ana_start_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ANA: state_d = S_WAIT_ANA;
            S_WAIT_ANA: begin
                if (ana_done) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Write side. Once every frame of the run has been written, further
        // samples are silently ignored rather than counted as overflow.
        if (fir_valid && (frames_wr_q != CW'(NUM_FRAMES))) begin
            if (full_q[wr_bank_q]) begin
                overflow_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = {wr_bank_q, wr_idx_q};
                wr_data_d = fir_d;
                if (wr_idx_q == IW'(FRAME_LEN - 1)) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    wr_idx_d          = '0;
                    frames_wr_d       = frames_wr_q + CW'(1);
                end else begin
                    wr_idx_d = wr_idx_q + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_bank_q   <= 1'b0;
            full_q      <= 2'b00;
            frames_wr_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            fft_start_q <= 1'b0;
            fft_bank_q  <= 1'b0;
            ana_start_q <= 1'b0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            frames_wr_q <= frames_wr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            fft_start_q <= fft_start_d;
            fft_bank_q  <= fft_bank_d;
            ana_start_q <= ana_start_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign fft_start = fft_start_q;
    assign fft_bank  = fft_bank_q;
    assign ana_start = ana_start_q;
    assign frame_cnt = frame_cnt_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fas_frame_sched.sv
// Bench for fas_frame_sched: directed steps in one initial block, with a
// scoreboard of expected buffer writes and expected FFT banks that is filled
// as samples are driven and drained as the design produces them.
module tb_fas_frame_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        fir_valid;
    logic [15:0] fir_d;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        fft_start;
    logic        fft_bank;
    logic        fft_done;
    logic        ana_start;
    logic        ana_done;
    logic [6:0]  frame_cnt;
    logic        overflow;
    logic        done;

    logic fft_done_man;
    logic fft_done_auto;
    logic auto_fft;
    assign fft_done = fft_done_man | fft_done_auto;

    fas_frame_sched dut (
        .clk       (clk),
        .rst       (rst),
        .fir_valid (fir_valid),
        .fir_d     (fir_d),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .fft_start (fft_start),
        .fft_bank  (fft_bank),
        .fft_done  (fft_done),
        .ana_start (ana_start),
        .ana_done  (ana_done),
        .frame_cnt (frame_cnt),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [20:0] wq[$];   // expected {addr, data} per accepted sample
    logic        bq[$];   // expected fft_bank per completed frame
    logic        m_bank;
    logic [3:0]  m_idx;

    int start_cnt = 0;
    int last_start_cyc = 0;
    int ana_cnt = 0;
    int ana_cyc = 0;
    int auto_done_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr"}, {10'd0, wr_en, wr_addr, wr_data}, 32'd0);
        check({tag, "_ctl"}, {20'd0, fft_start, fft_bank, ana_start, frame_cnt, overflow, done}, 32'd0);
    endtask

    // Output monitor: drains the scoreboard as writes and launches appear.
    always @(negedge clk) begin
        if (wr_en) begin
            check("wr_expected", {31'd0, wq.size() > 0}, 32'd1);
            if (wq.size() > 0) begin
                logic [20:0] e;
                e = wq.pop_front();
                check("wr_addr", {27'd0, wr_addr}, {27'd0, e[20:16]});
                check("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
            end
        end
        if (fft_start) begin
            start_cnt++;
            last_start_cyc = cyc;
            check("fft_expected", {31'd0, bq.size() > 0}, 32'd1);
            if (bq.size() > 0) begin
                logic b;
                b = bq.pop_front();
                check("fft_bank", {31'd0, fft_bank}, {31'd0, b});
            end
        end
        if (ana_start) begin
            ana_cnt++;
            ana_cyc = cyc;
        end
    end

    // FFT engine stand-in: answers each launch with fft_done 8 cycles later.
    initial begin
        fft_done_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (fft_start && auto_fft) begin
                repeat (8) @(posedge clk);
                #1 fft_done_auto = 1'b1;
                auto_done_cyc = cyc;
                @(posedge clk);
                #1 fft_done_auto = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [15:0] d);
        fir_valid = 1'b1;
        fir_d     = d;
        @(posedge clk);
        #1 fir_valid = 1'b0;
    endtask

    task automatic send_acc(input logic [15:0] d);
        wq.push_back({m_bank, m_idx, d});
        if (m_idx == 4'hF) begin
            bq.push_back(m_bank);
            m_bank = ~m_bank;
        end
        m_idx = m_idx + 4'd1;
        drive(d);
    endtask

    task automatic pulse_fft_done();
        fft_done_man = 1'b1;
        idle(1);
        fft_done_man = 1'b0;
    endtask

    task automatic pulse_ana_done();
        ana_done = 1'b1;
        idle(1);
        ana_done = 1'b0;
    endtask

    task automatic do_reset();
        auto_fft     = 1'b0;
        fir_valid    = 1'b0;
        fft_done_man = 1'b0;
        ana_done     = 1'b0;
        #1 rst = 1'b0;
        #1;
        wq.delete();
        bq.delete();
        m_bank    = 1'b0;
        m_idx     = 4'd0;
        start_cnt = 0;
        ana_cnt   = 0;
        idle(1);
        rst = 1'b1;
        idle(1);
    endtask

    initial begin
        int s15;
        int s31;
        int dcyc;

        rst = 1'b0; fir_valid = 1'b0; fir_d = '0;
        fft_done_man = 1'b0; ana_done = 1'b0; auto_fft = 1'b0;
        m_bank = 1'b0; m_idx = 4'd0;
        #2 check_zero("reset_state");
        @(posedge clk); #1 rst = 1'b1;
        idle(1);

        // T1: asynchronous reset mid-frame, then restart at address 0
        for (int i = 0; i < 5; i++) send_acc(16'h0011 + 16'(i));
        rst = 1'b0;
        #1 check_zero("t1_async");
        wq.delete(); bq.delete(); m_bank = 1'b0; m_idx = 4'd0;
        idle(2);
        rst = 1'b1;
        idle(1);
        send_acc(16'hABCD);
        idle(2);
        check("t1_wq_empty", wq.size(), 0);

        // T3: addressing of 32 samples and launch latency
        do_reset();
        auto_fft = 1'b1;
        s15 = 0; s31 = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 15) s15 = cyc;
            if (i == 31) s31 = cyc;
            send_acc(16'(i));
            if (i == 20) check("t3_lat_frame0", last_start_cyc - s15, 2);
        end
        idle(4);
        check("t3_lat_frame1", last_start_cyc - s31, 2);
        for (int k = 0; k < 40 && frame_cnt != 7'd2; k++) idle(1);
        check("t3_frame_cnt", {25'd0, frame_cnt}, 2);
        check("t3_starts", start_cnt, 2);
        check("t3_wq_empty", wq.size(), 0);
        idle(2);

        // T2: full 1024-sample run
        do_reset();
        auto_fft = 1'b1;
        for (int i = 0; i < 1024; i++) send_acc(16'($urandom));
        for (int k = 0; k < 100 && ana_cnt == 0; k++) idle(1);
        check("t2_ana_once", ana_cnt, 1);
        check("t2_ana_lat", ana_cyc - auto_done_cyc, 1);
        check("t2_starts", start_cnt, 64);
        check("t2_frame_cnt", {25'd0, frame_cnt}, 64);
        check("t2_overflow", {31'd0, overflow}, 0);
        idle(3);
        check("t2_done_wait", {31'd0, done}, 0);
        pulse_ana_done();
        check("t2_done", {31'd0, done}, 1);
        drive(16'h5555);   // beyond the run: ignored, not an overflow
        idle(3);
        check("t2_done_held", {31'd0, done}, 1);
        check("t2_extra_ignored", {31'd0, overflow}, 0);
        check("t2_ana_still_once", ana_cnt, 1);
        check("t2_wq_empty", wq.size(), 0);
        check("t2_bq_empty", bq.size(), 0);

        // T4: overflow while the FFT is stalled
        do_reset();
        for (int i = 0; i < 32; i++) send_acc(16'h0100 + 16'(i));
        check("t4_ovf_pre", {31'd0, overflow}, 0);
        drive(16'h0200);
        check("t4_ovf_set", {31'd0, overflow}, 1);
        for (int i = 1; i < 8; i++) drive(16'h0200 + 16'(i));
        idle(2);
        check("t4_frame_cnt0", {25'd0, frame_cnt}, 0);
        check("t4_starts1", start_cnt, 1);
        dcyc = cyc;
        pulse_fft_done();
        idle(4);
        check("t4_starts2", start_cnt, 2);
        check("t4_restart_lat", last_start_cyc - dcyc, 2);
        check("t4_frame_cnt1", {25'd0, frame_cnt}, 1);
        send_acc(16'h0ABC);   // model expects bank 0, index 0
        idle(2);
        check("t4_ovf_sticky", {31'd0, overflow}, 1);
        check("t4_wq_empty", wq.size(), 0);

        // T5: stray handshakes are ignored
        do_reset();
        pulse_fft_done();
        idle(2);
        check("t5_fcnt_idle", {25'd0, frame_cnt}, 0);
        check("t5_no_start", start_cnt, 0);
        pulse_ana_done();
        idle(2);
        check("t5_done_idle", {31'd0, done}, 0);
        check("t5_no_ana", ana_cnt, 0);
        s15 = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) s15 = cyc;
            send_acc(16'h0300 + 16'(i));
        end
        idle(3);
        check("t5_start", start_cnt, 1);
        check("t5_lat", last_start_cyc - s15, 2);
        pulse_ana_done();
        idle(1);
        check("t5_done_waitfft", {31'd0, done}, 0);
        check("t5_fcnt_waitfft", {25'd0, frame_cnt}, 0);
        pulse_fft_done();
        check("t5_fcnt_after", {25'd0, frame_cnt}, 1);
        idle(3);
        check("t5_no_extra_start", start_cnt, 1);

        // T6: fft_done coincides with the 16th write of the other bank
        do_reset();
        for (int i = 0; i < 31; i++) send_acc(16'h0400 + 16'(i));
        fft_done_man = 1'b1;
        s31 = cyc;
        send_acc(16'h041F);
        fft_done_man = 1'b0;
        idle(4);
        check("t6_starts", start_cnt, 2);
        check("t6_lat", last_start_cyc - s31, 2);
        check("t6_frame_cnt", {25'd0, frame_cnt}, 1);
        for (int i = 0; i < 16; i++) send_acc(16'h0500 + 16'(i));
        idle(2);
        check("t6_no_drop", {31'd0, overflow}, 0);
        check("t6_wq_empty", wq.size(), 0);
        check("t6_bq_pending", bq.size(), 1);

        // T7: a sample aimed at a bank being released that cycle is dropped
        do_reset();
        for (int i = 0; i < 32; i++) send_acc(16'h0600 + 16'(i));
        idle(2);
        check("t7_ovf_pre", {31'd0, overflow}, 0);
        fft_done_man = 1'b1;
        drive(16'hDEAD);
        fft_done_man = 1'b0;
        check("t7_drop_on_clear", {31'd0, overflow}, 1);
        idle(3);
        send_acc(16'hBEEF);
        idle(2);
        check("t7_wq_empty", wq.size(), 0);
        check("t7_starts", start_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
